conv_layer_stream: RTL and testbench

//  Parametrised int8 conv layer: buffers one IN_CH x IN_H x IN_W frame, runs a valid KxK

---
 rtl/conv_layer_stream.sv | 220 ++++++++++++++++++++++
 tb/tb_conv_layer_stream.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_stream.sv
// conv_layer_stream: buffers one int8 feature frame, runs a valid KxK convolution with a
// single serial MAC per tap, adds per-channel bias, requantises with ReLU/saturation and an
// optional 2x2 max-pool, then emits one OUT_CH-byte pixel per valid/ready handshake.
module conv_layer_stream #(
    parameter int IN_CH  = 6,
    parameter int OUT_CH = 16,
    parameter int IN_W   = 12,
    parameter int IN_H   = 12,
    parameter int K      = 5,
    parameter int POOL   = 1,
    parameter int SHIFT  = 7,
    parameter int ACC_W  = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [8*IN_CH-1:0]                     in_data,
    output logic [$clog2(OUT_CH*IN_CH*K*K)-1:0]    w_addr,
    input  logic signed [7:0]                      w_data,
    output logic [$clog2(OUT_CH)-1:0]              b_addr,
    input  logic signed [ACC_W-1:0]                b_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [8*OUT_CH-1:0]                    out_data,
    output logic                                   busy
);

    localparam int CONV_W = IN_W - K + 1;
    localparam int CONV_H = IN_H - K + 1;
    localparam int STEP   = (POOL != 0) ? 2 : 1;
    localparam int OUT_W  = CONV_W / STEP;
    localparam int OUT_H  = CONV_H / STEP;
    localparam int NSUB   = STEP * STEP;
    localparam int TAPS   = IN_CH * K * K;
    localparam int NPIX   = IN_W * IN_H;
    localparam int WA_W   = $clog2(OUT_CH * TAPS);
    localparam int BA_W   = $clog2(OUT_CH);
    localparam int FA_W   = $clog2(NPIX);
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {S_LOAD, S_CONV, S_EMIT} state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         la_q;
    logic [CNT_W-1:0]         t_q;
    logic [CNT_W-1:0]         ic_q;
    logic [CNT_W-1:0]         ky_q;
    logic [CNT_W-1:0]         kx_q;
    logic [CNT_W-1:0]         oc_q;
    logic [CNT_W-1:0]         px_q;
    logic [CNT_W-1:0]         py_q;
    logic [1:0]               sub_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [6:0]               max_q;
    logic signed [7:0]        feat_q;
    logic [8*OUT_CH-1:0]      out_data_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic [8*IN_CH-1:0]       fmem_q [NPIX];

    logic [FA_W-1:0]          faddr_d;
    logic signed [7:0]        feat_d;
    logic signed [15:0]       prod_d;
    logic signed [ACC_W-1:0]  prod_ext_d;
    logic signed [ACC_W-1:0]  r_d;
    logic [6:0]               q_d;
    logic [6:0]               max_d;
    logic                     last_tap_d;
    logic                     last_pix_d;

    // Feature address of the current tap and the selected input-channel byte
    always_comb begin
        int cy;
        int cx;
        int fa;
        logic [8*IN_CH-1:0] row;
        cy = int'(py_q) * STEP + int'(sub_q[1]);
        cx = int'(px_q) * STEP + int'(sub_q[0]);
        fa = (cy + int'(ky_q)) * IN_W + cx + int'(kx_q);
        faddr_d = FA_W'(fa);
        row = fmem_q[faddr_d];
        feat_d = '0;
        for (int unsigned c = 0; c < IN_CH; c++) begin
            if (ic_q == CNT_W'(c)) feat_d = row[8*c +: 8];
        end
    end

    // MAC product, requantisation and running pool maximum
    always_comb begin
        prod_d     = w_data * feat_q;
        prod_ext_d = {{(ACC_W-16){prod_d[15]}}, prod_d};
        r_d        = acc_q >>> SHIFT;
        if (r_d < 0)
            q_d = '0;
        else if (r_d > 127)
            q_d = 7'd127;
        else
            q_d = r_d[6:0];
        max_d      = (sub_q == 2'd0 || q_d > max_q) ? q_d : max_q;
        last_tap_d = (t_q == CNT_W'(TAPS + 1));
        last_pix_d = (px_q == CNT_W'(OUT_W - 1)) && (py_q == CNT_W'(OUT_H - 1));
    end

    // Frame buffer write during LOAD and registered read of the tap operand
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && in_valid && in_ready_q)
            fmem_q[FA_W'(la_q)] <= in_data;
        feat_q <= feat_d;
    end

    // Control FSM: LOAD frame, CONV one output pixel, EMIT it under backpressure
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            la_q        <= '0;
            t_q         <= '0;
            ic_q        <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            oc_q        <= '0;
            px_q        <= '0;
            py_q        <= '0;
            sub_q       <= '0;
            acc_q       <= '0;
            max_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        if (la_q == CNT_W'(NPIX - 1)) begin
                            la_q       <= '0;
                            state_q    <= S_CONV;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            la_q <= la_q + 1'b1;
                        end
                    end
                end
                S_CONV: begin
                    // Tap counters step once per issued address; they wrap to zero after
                    // the last tap so the next segment starts clean.
                    if (t_q < CNT_W'(TAPS)) begin
                        if (kx_q == CNT_W'(K - 1)) begin
                            kx_q <= '0;
                            if (ky_q == CNT_W'(K - 1)) begin
                                ky_q <= '0;
                                ic_q <= (ic_q == CNT_W'(IN_CH - 1)) ? '0 : ic_q + 1'b1;
                            end else begin
                                ky_q <= ky_q + 1'b1;
                            end
                        end else begin
                            kx_q <= kx_q + 1'b1;
                        end
                    end
                    if (t_q == CNT_W'(1))
                        acc_q <= b_data + prod_ext_d;
                    else if (t_q >= CNT_W'(2) && t_q <= CNT_W'(TAPS))
                        acc_q <= acc_q + prod_ext_d;
                    if (last_tap_d) begin
                        t_q   <= '0;
                        max_q <= max_d;
                        if (sub_q == 2'(NSUB - 1)) begin
                            sub_q <= '0;
                            for (int unsigned c = 0; c < OUT_CH; c++) begin
                                if (oc_q == CNT_W'(c)) out_data_q[8*c +: 8] <= {1'b0, max_d};
                            end
                            if (oc_q == CNT_W'(OUT_CH - 1)) begin
                                oc_q        <= '0;
                                state_q     <= S_EMIT;
                                out_valid_q <= 1'b1;
                            end else begin
                                oc_q <= oc_q + 1'b1;
                            end
                        end else begin
                            sub_q <= sub_q + 1'b1;
                        end
                    end else begin
                        t_q <= t_q + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_pix_d) begin
                            px_q       <= '0;
                            py_q       <= '0;
                            state_q    <= S_LOAD;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= S_CONV;
                            if (px_q == CNT_W'(OUT_W - 1)) begin
                                px_q <= '0;
                                py_q <= py_q + 1'b1;
                            end else begin
                                px_q <= px_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign w_addr    = WA_W'(((int'(oc_q) * IN_CH + int'(ic_q)) * K + int'(ky_q)) * K + int'(kx_q));
    assign b_addr    = BA_W'(oc_q);
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_conv_layer_stream.sv
// Bench for conv_layer_stream: small configuration, randomised frames/weights/biases,
// expected pixels from a direct nested-loop convolution model.
module tb_conv_layer_stream;

    localparam int IN_CH  = 2;
    localparam int OUT_CH = 4;
    localparam int IN_W   = 6;
    localparam int IN_H   = 6;
    localparam int K      = 3;
    localparam int POOL   = 1;
    localparam int SHIFT  = 2;
    localparam int ACC_W  = 32;

    localparam int STEP    = (POOL != 0) ? 2 : 1;
    localparam int OUT_W   = (IN_W - K + 1) / STEP;
    localparam int OUT_H   = (IN_H - K + 1) / STEP;
    localparam int NOUT    = OUT_W * OUT_H;
    localparam int NPIX    = IN_W * IN_H;
    localparam int TAPS    = IN_CH * K * K;
    localparam int NW      = OUT_CH * TAPS;
    localparam int PIX_CYC = STEP * STEP * OUT_CH * (TAPS + 2);
    localparam int WA_W    = $clog2(NW);
    localparam int BA_W    = $clog2(OUT_CH);

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [8*IN_CH-1:0]       in_data;
    logic [WA_W-1:0]          w_addr;
    logic signed [7:0]        w_data;
    logic [BA_W-1:0]          b_addr;
    logic signed [ACC_W-1:0]  b_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [8*OUT_CH-1:0]      out_data;
    logic                     busy;

    int n_vec = 0;
    int n_err = 0;

    int wmem [NW];
    int bmem [OUT_CH];
    int frame [IN_H][IN_W][IN_CH];

    conv_layer_stream #(
        .IN_CH (IN_CH),
        .OUT_CH(OUT_CH),
        .IN_W  (IN_W),
        .IN_H  (IN_H),
        .K     (K),
        .POOL  (POOL),
        .SHIFT (SHIFT),
        .ACC_W (ACC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Weight and bias memories with one cycle of read latency
    always @(posedge clk) begin
        w_data <= 8'(wmem[w_addr]);
        b_data <= bmem[b_addr];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 5 ms");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(hi - lo));
    endfunction

    function automatic logic [8*OUT_CH-1:0] model_pixel(input int px, input int py);
        logic [8*OUT_CH-1:0] res;
        res = '0;
        for (int oc = 0; oc < OUT_CH; oc++) begin
            int best;
            best = 0;
            for (int s = 0; s < STEP * STEP; s++) begin
                int cy, cx, acc, r, q;
                cy  = py * STEP + s / 2;
                cx  = px * STEP + s % 2;
                acc = bmem[oc];
                for (int ic = 0; ic < IN_CH; ic++)
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++)
                            acc += wmem[((oc * IN_CH + ic) * K + ky) * K + kx]
                                   * frame[cy + ky][cx + kx][ic];
                r = acc >>> SHIFT;
                q = (r < 0) ? 0 : ((r > 127) ? 127 : r);
                if (q > best) best = q;
            end
            res[8*oc +: 8] = 8'(best);
        end
        return res;
    endfunction

    task automatic fill(input int wlo, input int whi, input int blo, input int bhi,
                        input int flo, input int fhi);
        for (int i = 0; i < NW; i++) wmem[i] = rnd(wlo, whi);
        for (int i = 0; i < OUT_CH; i++) bmem[i] = rnd(blo, bhi);
        for (int y = 0; y < IN_H; y++)
            for (int x = 0; x < IN_W; x++)
                for (int c = 0; c < IN_CH; c++) frame[y][x][c] = rnd(flo, fhi);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_w_addr", w_addr, 0);
        check_eq("rst_b_addr", b_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_frame(input bit gaps, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int g;
            g = gaps ? int'($urandom_range(2)) : 0;
            in_valid = 1'b0;
            in_data  = '1;
            repeat (g) @(negedge clk);
            for (int c = 0; c < IN_CH; c++)
                in_data[8*c +: 8] = 8'(frame[i / IN_W][i % IN_W][c]);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int stall_beat, input int stall_len, input bit rnd_ready);
        for (int b = 0; b < NOUT; b++) begin
            int cnt;
            int bad;
            logic [8*OUT_CH-1:0] exp;
            cnt = 0;
            while (!out_valid && cnt < PIX_CYC + 50) begin
                @(negedge clk);
                cnt++;
            end
            check_eq("latency", cnt, PIX_CYC);
            if (!out_valid) begin
                check_eq("out_valid_timeout", out_valid, 1);
                return;
            end
            exp = model_pixel(b % OUT_W, b / OUT_W);
            if (b == stall_beat) begin
                bad = 0;
                repeat (stall_len) begin
                    @(negedge clk);
                    if (!out_valid || out_data !== exp) bad++;
                end
                check_eq("stall_hold", bad, 0);
            end else if (rnd_ready) begin
                repeat ($urandom_range(3)) @(negedge clk);
            end
            check_eq("pixel", out_data, exp);
            check_eq("busy_emit", busy, 1);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check_eq("valid_drop", out_valid, 0);
        end
        check_eq("back_to_load", {in_ready, busy}, 2'b10);
    endtask

    task automatic run_frame(input bit gaps, input int stall_beat, input int stall_len,
                             input bit rnd_ready);
        load_frame(gaps, NPIX);
        check_eq("loaded_state", {in_ready, busy, out_valid}, 3'b010);
        collect(stall_beat, stall_len, rnd_ready);
    endtask

    initial begin
        in_data = '0;
        do_reset();

        // All-zero weights and biases give all-zero pixels
        fill(0, 0, 0, 0, -128, 127);
        run_frame(1'b1, -1, 0, 1'b0);

        // Bias only: byte oc carries oc*30 after the shift
        fill(0, 0, 0, 0, -128, 127);
        for (int oc = 0; oc < OUT_CH; oc++) bmem[oc] = (oc * 30) << SHIFT;
        run_frame(1'b0, -1, 0, 1'b0);

        // Unit weights over an all-ones frame, then an all-minus-one frame (ReLU floor)
        fill(1, 1, 0, 0, 1, 1);
        run_frame(1'b0, -1, 0, 1'b1);
        fill(1, 1, 0, 0, -1, -1);
        run_frame(1'b0, -1, 0, 1'b1);

        // Single tap at (ic0,0,0), ch0 = x+y: pooled output picks the max corner
        fill(0, 0, 0, 0, -20, 20);
        for (int oc = 0; oc < OUT_CH; oc++) wmem[oc * TAPS] = 1 << SHIFT;
        for (int y = 0; y < IN_H; y++)
            for (int x = 0; x < IN_W; x++) frame[y][x][0] = x + y;
        run_frame(1'b1, -1, 0, 1'b0);

        // Full-range values (heavy saturation) with a 100-cycle stall on beat 2
        fill(-128, 127, -5000, 5000, -128, 127);
        run_frame(1'b1, 2, 100, 1'b0);

        // Small values keep results inside the linear range
        repeat (2) begin
            fill(-6, 6, -300, 300, -9, 9);
            run_frame(1'b1, -1, 0, 1'b1);
        end

        // Reset during CONV, then the same frame must give a clean result
        fill(-6, 6, -300, 300, -9, 9);
        load_frame(1'b0, NPIX);
        repeat (150) @(negedge clk);
        do_reset();
        run_frame(1'b1, -1, 0, 1'b1);

        // Reset part-way through LOAD discards the partial frame
        fill(-10, 10, -500, 500, -12, 12);
        load_frame(1'b0, 10);
        do_reset();
        run_frame(1'b0, 1, 7, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
